// File: rtl/ppu_pkg.sv
// Shared object-pipeline types for the PPU.
//   obj_entry_t : one OAM entry as read from the two 16-bit OAM words.
//   obj_slot_t  : what a line slot keeps for one visible object.
//   scan_state_t: line selector scan FSM states.
//   obj_visible : vertical range test for 8x8 / 8x16 objects.
package ppu_pkg;

  localparam int OBJ_H_SHORT = 8;
  localparam int OBJ_H_TALL  = 16;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] tile;
    logic [7:0] attrs;
  } obj_entry_t;

  // index is sized for the largest supported OAM (64 entries).
  typedef struct packed {
    logic [7:0] sx;
    logic [7:0] tile;
    logic [3:0] dy;
    logic [3:0] attrs;
    logic [5:0] index;
  } obj_slot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } scan_state_t;

  function automatic logic obj_visible(input logic [7:0] dy, input logic tall);
    return tall ? (dy < 8'(OBJ_H_TALL)) : (dy < 8'(OBJ_H_SHORT));
  endfunction

endpackage

// File: rtl/obj_line_selector_if.sv
// Renderer query port of the object line selector.
//   master : renderer side, drives q_valid / q_x / q_take, receives hit data.
//   slave  : selector side.
interface obj_line_selector_if #(
  parameter int N_OAM = 40
);
  localparam int IDX_W = (N_OAM > 1) ? $clog2(N_OAM) : 1;

  logic             q_valid;
  logic [7:0]       q_x;
  logic             q_take;
  logic             hit;
  logic [7:0]       hit_tile;
  logic [2:0]       hit_row;
  logic [3:0]       hit_attrs;
  logic [IDX_W-1:0] hit_index;

  modport master (
    output q_valid, q_x, q_take,
    input  hit, hit_tile, hit_row, hit_attrs, hit_index
  );

  modport slave (
    input  q_valid, q_x, q_take,
    output hit, hit_tile, hit_row, hit_attrs, hit_index
  );
endinterface

// File: rtl/obj_line_selector_slot.sv
// obj_slot: one object slot of the line selector.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : empty the slot (new scan)
//   load     : fill the slot with data_in and mark it live
//   retire   : empty the slot after its object has been consumed
//   q_x      : queried screen X
//   live     : slot holds an object
//   data     : stored object
//   match    : live and stored sx equals q_x
module obj_slot
  import ppu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      load,
  input  logic      retire,
  input  logic [7:0] q_x,
  input  obj_slot_t data_in,
  output logic      live,
  output obj_slot_t data,
  output logic      match
);

  logic      live_reg;
  obj_slot_t data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_reg <= 1'b0;
      data_reg <= '0;
    end else if (clr) begin
      live_reg <= 1'b0;
    end else if (load) begin
      live_reg <= 1'b1;
      data_reg <= data_in;
    end else if (retire) begin
      live_reg <= 1'b0;
    end
  end

  assign live  = live_reg;
  assign data  = data_reg;
  assign match = live_reg && (data_reg.sx == q_x);

endmodule

// File: rtl/obj_line_selector.sv
// obj_line_selector: scans OAM for the current line, keeps the first N_SLOTS
// visible objects in OAM order and answers per-pixel X queries.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : clear slots and (re)start the scan for ly / tall
//   ly, tall      : current line, 8x16 object mode
//   oam_addr/oam_d: OAM word read port (data one cycle after address)
//   scan_done     : slots hold a completed line
//   count         : slots filled; overflow: a visible object was dropped
//   q             : renderer query port (obj_line_selector_if.slave)
// Optional: define OBJ_YFLIP_EN to honour attrs[6] as vertical flip.
module obj_line_selector
  import ppu_pkg::*;
#(
  parameter int N_SLOTS = 10,
  parameter int N_OAM   = 40,
  parameter int Y_OFS   = 16,
  parameter int X_OFS   = 8,
  localparam int ADDR_W = $clog2(2 * N_OAM),
  localparam int CNT_W  = $clog2(N_SLOTS + 1),
  localparam int IDX_W  = (N_OAM > 1) ? $clog2(N_OAM) : 1,
  localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        ly,
  input  logic              tall,
  output logic [ADDR_W-1:0] oam_addr,
  input  logic [15:0]       oam_d,
  output logic              scan_done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  obj_line_selector_if.slave q
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(2 * N_OAM - 1);

  scan_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              issue_reg;      // addr_reg is a live read request
  logic              rd_valid_reg;   // oam_d carries word rd_word_reg
  logic [ADDR_W-1:0] rd_word_reg;
  logic [7:0]        ybuf_reg, xbuf_reg;
  logic              tall_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              overflow_reg;

  logic [N_SLOTS-1:0] slot_live, slot_match;
  obj_slot_t          slot_data [N_SLOTS];

  obj_entry_t        cur_entry;
  obj_slot_t         new_slot, win;
  logic [7:0]        dy;
  logic              capture_odd, visible, do_insert, do_drop, do_take;
  logic              free_found, win_found;
  logic [SLOT_W-1:0] free_idx, win_idx;
  logic [3:0]        row;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = ST_SCAN;
    end else if (state_reg == ST_SCAN && rd_valid_reg && rd_word_reg == LAST_WORD) begin
      state_next = ST_DONE;
    end
  end

  // ---------------- entry assembly / visibility ----------------
  always_comb begin
    cur_entry = '{y: ybuf_reg, x: xbuf_reg, tile: oam_d[15:8], attrs: oam_d[7:0]};
    dy        = ly + 8'(Y_OFS) - cur_entry.y;
    visible   = obj_visible(dy, tall_reg);
    new_slot  = '{sx:    cur_entry.x - 8'(X_OFS),
                  tile:  cur_entry.tile,
                  dy:    dy[3:0],
                  attrs: cur_entry.attrs[7:4],
                  index: 6'(rd_word_reg >> 1)};
  end

  assign capture_odd = (state_reg == ST_SCAN) && rd_valid_reg && rd_word_reg[0];
  assign do_insert   = capture_odd && visible && free_found && !start;
  assign do_drop     = capture_odd && visible && !free_found && !start;

  // Lowest empty slot for inserts, lowest matching slot for queries.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    win_found  = 1'b0;
    win_idx    = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!slot_live[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
      if (slot_match[i]) begin
        win_found = 1'b1;
        win_idx   = SLOT_W'(i);
      end
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg     <= '0;
      issue_reg    <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_word_reg  <= '0;
      ybuf_reg     <= '0;
      xbuf_reg     <= '0;
      tall_reg     <= 1'b0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (start) begin
      addr_reg     <= '0;
      issue_reg    <= 1'b1;
      rd_valid_reg <= 1'b0;
      tall_reg     <= tall;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (state_reg == ST_SCAN) begin
        rd_valid_reg <= issue_reg;
        rd_word_reg  <= addr_reg;
        if (issue_reg) begin
          if (addr_reg == LAST_WORD) issue_reg <= 1'b0;
          else                       addr_reg  <= addr_reg + 1'b1;
        end
        if (rd_valid_reg && !rd_word_reg[0]) begin
          ybuf_reg <= oam_d[15:8];
          xbuf_reg <= oam_d[7:0];
        end
      end
      if (do_insert)    count_reg    <= count_reg + 1'b1;
      else if (do_take) count_reg    <= count_reg - 1'b1;
      if (do_drop)      overflow_reg <= 1'b1;
    end
  end

  // ---------------- slots ----------------
  generate
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      obj_slot u_slot (
        .clk     (clk),
        .rst     (rst),
        .clr     (start),
        .load    (do_insert && (free_idx == SLOT_W'(gi))),
        .retire  (do_take && (win_idx == SLOT_W'(gi))),
        .q_x     (q.q_x),
        .data_in (new_slot),
        .live    (slot_live[gi]),
        .data    (slot_data[gi]),
        .match   (slot_match[gi])
      );
    end
  endgenerate

  // ---------------- query outputs ----------------
  assign win     = slot_data[win_idx];
  assign q.hit   = q.q_valid && (state_reg == ST_DONE) && win_found;
  assign do_take = q.hit && q.q_take;

  always_comb begin
    row = win.dy;
`ifdef OBJ_YFLIP_EN
    if (win.attrs[2]) row = (tall_reg ? 4'd15 : 4'd7) - win.dy;
`endif
  end

  // In 8x16 mode the lower tile of the pair is selected by row bit 3.
  assign q.hit_tile  = tall_reg ? {win.tile[7:1], row[3]} : win.tile;
  assign q.hit_row   = row[2:0];
  assign q.hit_attrs = win.attrs;
  assign q.hit_index = win.index[IDX_W-1:0];

  assign oam_addr  = addr_reg;
  assign scan_done = (state_reg == ST_DONE);
  assign count     = count_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_obj_line_selector.sv
module tb_obj_line_selector;
  import ppu_pkg::*;

  localparam int N_SLOTS = 10;
  localparam int N_OAM   = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  ly = '0;
  logic        tall = 1'b0;
  logic [6:0]  oam_addr;
  logic [15:0] oam_d = '0;
  logic        scan_done;
  logic [3:0]  count;
  logic        overflow;

  logic [15:0] mem [0:127];

  int n_checks = 0;
  int n_fail   = 0;

  obj_line_selector_if #(.N_OAM(N_OAM)) qif ();

  obj_line_selector #(.N_SLOTS(N_SLOTS), .N_OAM(N_OAM), .Y_OFS(16), .X_OFS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ly        (ly),
    .tall      (tall),
    .oam_addr  (oam_addr),
    .oam_d     (oam_d),
    .scan_done (scan_done),
    .count     (count),
    .overflow  (overflow),
    .q         (qif.slave)
  );

  always #5 clk = ~clk;

  // OAM model: registered read, data one cycle after address.
  always @(posedge clk) oam_d <= mem[oam_addr];

  typedef struct {
    logic       q_valid;
    logic [7:0] q_x;
    logic       exp_hit;
    logic [7:0] exp_tile;
    logic [2:0] exp_row;
    logic [3:0] exp_attrs;
    int         exp_index;
  } qvec_t;

  qvec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
  endtask

  task automatic set_entry(input int i, input logic [7:0] y, input logic [7:0] x,
                           input logic [7:0] tile, input logic [7:0] attrs);
    mem[2*i]   = {y, x};
    mem[2*i+1] = {tile, attrs};
  endtask

  task automatic pulse_start(input logic [7:0] l, input logic t);
    @(negedge clk);
    ly = l; tall = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges from the start edge until scan_done is seen.
  task automatic wait_done(input string name);
    int n;
    n = 1;
    @(posedge clk); #1;
    while (!scan_done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, n, 2*N_OAM + 1);
    $display("scan %s: scan_done after %0d cycles, count=%0d overflow=%0d", name, n, count, overflow);
  endtask

  task automatic query(input logic v, input logic [7:0] x);
    @(negedge clk);
    qif.q_valid = v; qif.q_x = x; qif.q_take = 1'b0;
    #1;
  endtask

  task automatic take();
    @(negedge clk);
    qif.q_take = 1'b1;
    @(negedge clk);
    qif.q_take = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    qif.q_valid = 1'b0; qif.q_x = '0; qif.q_take = 1'b0;
    clear_oam();

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    query(1'b1, 8'd42);
    chk("reset_count", count, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_scan_done", scan_done, 0);
    chk("reset_hit", qif.hit, 0);
    chk("reset_oam_addr", oam_addr, 0);
    $display("reset: count=%0d overflow=%0d scan_done=%0d hit=%0d", count, overflow, scan_done, qif.hit);

    // ---------------- mixed line, table-driven queries ----------------
    set_entry(0,  8'd30, 8'd50,  8'h12, 8'h00); // dy 6, sx 42
    set_entry(1,  8'd36, 8'd60,  8'h34, 8'hA0); // dy 0, sx 52
    set_entry(2,  8'd29, 8'd8,   8'h55, 8'h30); // dy 7, sx 0
    set_entry(3,  8'd28, 8'd20,  8'h66, 8'h00); // dy 8, hidden
    set_entry(4,  8'd40, 8'd100, 8'h67, 8'h00); // dy wraps, hidden
    set_entry(5,  8'd32, 8'd4,   8'h77, 8'h00); // dy 4, sx 252 clipped
    set_entry(39, 8'd35, 8'd167, 8'h99, 8'h10); // dy 1, sx 159, last entry

    vecs[0] = '{1'b1, 8'd42,  1'b1, 8'h12, 3'd6, 4'h0, 0};
    vecs[1] = '{1'b1, 8'd52,  1'b1, 8'h34, 3'd0, 4'hA, 1};
    vecs[2] = '{1'b1, 8'd0,   1'b1, 8'h55, 3'd7, 4'h3, 2};
    vecs[3] = '{1'b1, 8'd12,  1'b0, 8'h00, 3'd0, 4'h0, 0};
    vecs[4] = '{1'b1, 8'd4,   1'b0, 8'h00, 3'd0, 4'h0, 0};
    vecs[5] = '{1'b1, 8'd159, 1'b1, 8'h99, 3'd1, 4'h1, 39};
    vecs[6] = '{1'b1, 8'd92,  1'b0, 8'h00, 3'd0, 4'h0, 0};
    vecs[7] = '{1'b0, 8'd42,  1'b0, 8'h00, 3'd0, 4'h0, 0};

    pulse_start(8'd20, 1'b0);
    wait_done("scan1_latency");
    chk("scan1_count", count, 5);
    chk("scan1_overflow", overflow, 0);

    for (int i = 0; i < 8; i++) begin
      query(vecs[i].q_valid, vecs[i].q_x);
      $display("vec %0d: q_valid=%0d q_x=%0d hit=%0d tile=%h row=%0d attrs=%h index=%0d",
               i, vecs[i].q_valid, vecs[i].q_x, qif.hit, qif.hit_tile, qif.hit_row,
               qif.hit_attrs, qif.hit_index);
      chk($sformatf("vec%0d_hit", i), qif.hit, vecs[i].exp_hit);
      if (vecs[i].exp_hit) begin
        chk($sformatf("vec%0d_tile", i), qif.hit_tile, vecs[i].exp_tile);
        chk($sformatf("vec%0d_row", i), qif.hit_row, vecs[i].exp_row);
        chk($sformatf("vec%0d_attrs", i), qif.hit_attrs, vecs[i].exp_attrs);
        chk($sformatf("vec%0d_index", i), qif.hit_index, vecs[i].exp_index);
      end
    end

    // ---------------- overflow: 12 visible entries, 10 slots ----------------
    clear_oam();
    for (int i = 0; i < 12; i++) set_entry(i, 8'd16, 8'(18 + 10*i), 8'(i), 8'h00);
    pulse_start(8'd0, 1'b0);
    wait_done("ovf_latency");
    chk("ovf_count", count, 10);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < 12; i++) begin
      query(1'b1, 8'(10 + 10*i));
      $display("ovf query %0d: hit=%0d index=%0d", i, qif.hit, qif.hit_index);
      chk($sformatf("ovf_hit%0d", i), qif.hit, (i < 10) ? 1 : 0);
      if (i < 10) chk($sformatf("ovf_index%0d", i), qif.hit_index, i);
    end

    // ---------------- same-x priority and retirement ----------------
    clear_oam();
    set_entry(3, 8'd16, 8'd20, 8'h03, 8'h00);
    set_entry(7, 8'd16, 8'd20, 8'h07, 8'h00);
    pulse_start(8'd0, 1'b0);
    wait_done("prio_latency");
    chk("prio_count0", count, 2);
    query(1'b1, 8'd99);
    take();
    chk("take_no_hit_count", count, 2);
    query(1'b1, 8'd12);
    chk("prio_hit_a", qif.hit, 1);
    chk("prio_index_a", qif.hit_index, 3);
    $display("prio: first index=%0d", qif.hit_index);
    take();
    chk("prio_hit_b", qif.hit, 1);
    chk("prio_index_b", qif.hit_index, 7);
    chk("prio_count1", count, 1);
    $display("prio: second index=%0d count=%0d", qif.hit_index, count);
    take();
    chk("prio_hit_c", qif.hit, 0);
    chk("prio_count2", count, 0);

    // ---------------- tall object, optional Y flip ----------------
    clear_oam();
    set_entry(0, 8'd16, 8'd30, 8'h41, 8'h40);
    pulse_start(8'd10, 1'b1);
    wait_done("tall_latency");
    query(1'b1, 8'd22);
    $display("tall: hit=%0d tile=%h row=%0d", qif.hit, qif.hit_tile, qif.hit_row);
    chk("tall_hit", qif.hit, 1);
`ifdef OBJ_YFLIP_EN
    chk("tall_tile", qif.hit_tile, 8'h40);
    chk("tall_row", qif.hit_row, 5);
`else
    chk("tall_tile", qif.hit_tile, 8'h41);
    chk("tall_row", qif.hit_row, 2);
`endif
    chk("tall_attrs", qif.hit_attrs, 4);

    // ---------------- restart mid-scan, then async reset in DONE ----------------
    clear_oam();
    set_entry(0, 8'd30, 8'd50, 8'h12, 8'h00);
    pulse_start(8'd20, 1'b0);
    repeat (29) @(posedge clk);
    query(1'b1, 8'd42);
    chk("scan_hit_gated", qif.hit, 0);
    chk("scan_not_done", scan_done, 0);
    chk("scan_mid_count", count, 1);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    chk("restart_addr", oam_addr, 0);
    chk("restart_count", count, 0);
    @(negedge clk); start = 1'b0;
    wait_done("restart_latency");
    query(1'b1, 8'd42);
    chk("restart_hit", qif.hit, 1);
    chk("restart_count_done", count, 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    $display("async reset: hit=%0d count=%0d scan_done=%0d", qif.hit, count, scan_done);
    chk("arst_hit", qif.hit, 0);
    chk("arst_count", count, 0);
    chk("arst_scan_done", scan_done, 0);
    @(negedge clk); rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obj_line_selector.md
Name: obj_line_selector

Overview:
- Parametrised successor to the fixed 10-slot sprite chain.
- Scans all OAM entries for the current scan line and keeps the first N_SLOTS visible objects, in OAM order.
- Answers per-pixel X queries from the scanline renderer, with lowest-OAM-index priority and one-shot retirement per object.
- Adds a count output, sticky overflow flag, restartable scan and optional Y-flip; sits between OAM read port and renderer fetcher.

Parameters:
- N_SLOTS, 10, number of object slots per line (1..16).
- N_OAM, 40, number of OAM entries scanned (1..64).
- Y_OFS, 16, OAM Y bias subtracted from entry Y.
- X_OFS, 8, OAM X bias subtracted from entry X.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse: clear slots, begin scan for ly.
- ly  in  8  current line; must be stable from start until scan_done.
- tall  in  1  1 = 8x16 objects, 0 = 8x8; sampled at start.
- oam_addr  out  $clog2(2*N_OAM)  OAM word address (16-bit words).
- oam_d  in  16  OAM word; valid one cycle after oam_addr.
- scan_done  out  1  level; high while slots hold a completed line.
- count  out  $clog2(N_SLOTS+1)  number of slots filled.
- overflow  out  1  a visible object was dropped because all slots were full.
- q_valid  in  1  query active.
- q_x  in  8  screen X being queried.
- q_take  in  1  retire the currently presented hit at the next edge.
- hit  out  1  combinational: q_valid & scan_done & some live slot has x == q_x.
- hit_tile  out  8  tile index of the winning slot.
- hit_row  out  3  row within the 8-line tile.
- hit_attrs  out  4  OAM attrs[7:4].
- hit_index  out  $clog2(N_OAM)  OAM index of the winning slot.

Behaviour:
- Reset: state IDLE, oam_addr=0, all slots empty, count=0, overflow=0, scan_done=0, hit=0.
- States: IDLE -> SCAN on start; SCAN -> DONE after word 2*N_OAM-1 is captured; DONE -> SCAN on start. start in any state, including mid-SCAN, clears slots, count and overflow and restarts at address 0.
- SCAN:
  - oam_addr increments by 1 each cycle starting at 0.
  - Even word = {y[15:8], x[7:0]}, buffered.
  - Odd word = {tile[15:8], attrs[7:0]}, completes the entry.
  - scan_done rises exactly 2*N_OAM+1 cycles after the start edge.
- Visibility:
  - dy = ly + Y_OFS - y, 8-bit wrap.
  - Visible iff dy < 8, or dy < 16 when tall.
- Slot insert:
  - A visible entry goes to the lowest empty slot, storing sx = x - X_OFS (8-bit wrap), tile, dy[3:0], attrs[7:4] and index.
  - count increments.
  - If count == N_SLOTS, the entry is discarded and overflow is set; overflow is sticky until start or rst.
- Tile/row:
  - When tall, hit_tile = {tile[7:1], row[3]}; otherwise hit_tile = tile.
  - hit_row = row[2:0].
  - row = dy, or the Y-flipped value (see Optional Feature).
- Query:
  - Among live slots with sx == q_x, the lowest slot wins; this is the lowest OAM index.
  - On q_valid & hit & q_take, the winning slot is emptied at the edge and count decrements.
  - Further objects with the same x then present on the following cycle.
  - q_take without hit is ignored.
  - hit is forced to 0 outside DONE.
- Wrap: objects with x < X_OFS get sx >= 248 and never match on-screen q_x (0..159). This is accepted clipping.

Optional Feature:
- Macro OBJ_YFLIP_EN.
- Defined: when attrs[6] = 1, row = (tall ? 15 : 7) - dy.
- Undefined: row = dy always and attrs[6] is ignored; hit_attrs output is unchanged.

Decomposition:
- Shared package ppu_pkg holds:
  - obj_entry_t {y, x, tile, attrs};
  - obj_slot_t {sx, tile, dy, attrs, index};
  - OBJ_H_SHORT = 8, OBJ_H_TALL = 16.
- One sub-module obj_slot: a single slot register with a live bit, x-compare and load/retire controls.
- Priority encoding stays in the parent.

Test Plan:
- ly=20, tall=0, entry0 y=30 x=50 tile=0x12 -> dy=6, visible; scan_done at cycle 81; q_x=42 gives hit=1, hit_tile=0x12, hit_row=6, hit_index=0.
- 12 entries with y=16 at ly=0, N_SLOTS=10 -> count=10, overflow=1; entries 10 and 11 absent (hit_index never exceeds 9).
- Entries 3 and 7 both x=20 -> q_x=12 gives hit_index=3; q_take; next cycle gives hit_index=7; q_take; then hit=0 and count decrements by 2.
- tall=1, y=16, ly=10, tile=0x41 -> hit_tile=0x41, hit_row=2; with OBJ_YFLIP_EN and attrs=0x40 -> row=5, so hit_tile=0x40, hit_row=5.
- start pulsed at cycle 30 of a scan -> slots cleared, oam_addr returns to 0, scan_done 81 cycles after the second start; rst asserted mid-DONE -> hit=0 and count=0 immediately (asynchronous).
